// File: rtl/calc_core_param.sv
// calc_core_param: N-digit decimal calculator core (add/sub/mul, BCD display, busy handshake).
// Optional macro CALC_DIV_EN turns cmd 1111 into a restoring integer divide.
module calc_core_param #(
  parameter int NDIGITS = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [3:0]              cmd,
  input  logic                    cmd_valid,
  output logic [NDIGITS-1:0][6:0] displays,
  output logic [1:0]              status,
  output logic                    busy,
  output logic [2:0]              EA,
  output logic [2:0]              PE
);
  localparam logic [63:0] P10 = 64'd10 ** NDIGITS;
  localparam int W  = $clog2(P10);
  localparam int CW = $clog2(W + 1);
  localparam int BW = 4 * NDIGITS;
  localparam logic [W:0]     MAXP_W1 = (W+1)'(P10 - 64'd1);
  localparam logic [W-1:0]   MAXN_W  = W'(P10 / 64'd10 - 64'd1);
  localparam logic [2*W-1:0] MAXP_2W = (2*W)'(P10 - 64'd1);

  typedef enum logic [2:0] {
    ENTRY_A = 3'd0, ENTRY_B = 3'd1, CALC = 3'd2, CONV = 3'd3, SHOW = 3'd4, ERROR = 3'd5
  } state_t;

  state_t         r_state, w_next;
  logic [W-1:0]   r_a, r_b, r_mplier, r_bin;
  logic [2*W-1:0] r_acc, r_mcand;
  logic [BW-1:0]  r_bcd, w_bcd_adj;
  logic [1:0]     r_op, w_op_code;
  logic           r_neg, r_fresh;
  logic [3:0]     r_ndig;
  logic [CW-1:0]  r_cnt;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'h3F;  4'd1: seg7 = 7'h06;  4'd2: seg7 = 7'h5B;  4'd3: seg7 = 7'h4F;
      4'd4: seg7 = 7'h66;  4'd5: seg7 = 7'h6D;  4'd6: seg7 = 7'h7D;  4'd7: seg7 = 7'h07;
      4'd8: seg7 = 7'h7F;  4'd9: seg7 = 7'h6F;  default: seg7 = 7'h00;
    endcase
  endfunction

  logic w_accept, w_is_digit, w_is_op, w_clear, w_eq, w_last;
  assign busy       = (r_state == CALC) || (r_state == CONV);
  assign w_accept   = cmd_valid && !busy;
  assign w_is_digit = (cmd <= 4'd9);
  assign w_clear    = (cmd == 4'd13);
  assign w_eq       = (cmd == 4'd14);
`ifdef CALC_DIV_EN
  assign w_is_op    = ((cmd >= 4'd10) && (cmd <= 4'd12)) || (cmd == 4'd15);
`else
  assign w_is_op    = (cmd >= 4'd10) && (cmd <= 4'd12);
`endif
  assign w_op_code  = (cmd == 4'd15) ? 2'd3 : cmd[1:0] + 2'd2;
  assign w_last     = (r_cnt == CW'(W - 1));

  // SHOW/ERROR digits (and the first digit of B) start from an empty operand.
  logic [W-1:0]  w_base_op, w_dig_val;
  logic [BW-1:0] w_base_bcd;
  logic [3:0]    w_base_cnt, w_dig_cnt;
  logic          w_dig_ok;
  always_comb begin
    w_base_op  = '0;
    w_base_bcd = '0;
    w_base_cnt = '0;
    if (r_state == ENTRY_A) begin
      w_base_op = r_a; w_base_bcd = r_bcd; w_base_cnt = r_ndig;
    end else if (r_state == ENTRY_B && !r_fresh) begin
      w_base_op = r_b; w_base_bcd = r_bcd; w_base_cnt = r_ndig;
    end
  end
  assign w_dig_val = (w_base_op << 3) + (w_base_op << 1) + {{(W-4){1'b0}}, cmd};
  assign w_dig_cnt = (cmd == 4'd0 && w_base_op == '0) ? w_base_cnt : w_base_cnt + 4'd1;
  assign w_dig_ok  = (w_base_cnt < 4'(NDIGITS));

  logic [W:0]     w_sum;
  logic [W-1:0]   w_diff, w_res;
  logic [2*W-1:0] w_prod;
  logic           w_a_lt_b, w_res_neg, w_ovf, w_done;
  assign w_sum    = {1'b0, r_a} + {1'b0, r_b};
  assign w_a_lt_b = (r_a < r_b);
  assign w_diff   = w_a_lt_b ? (r_b - r_a) : (r_a - r_b);
  assign w_prod   = r_acc + (r_mplier[0] ? r_mcand : '0);
`ifdef CALC_DIV_EN
  logic [W:0]   w_rs, w_rs_sub;
  logic         w_ge;
  logic [W-1:0] w_quot;
  assign w_rs     = {r_acc[W-1:0], r_mplier[W-1]};
  assign w_ge     = (w_rs >= {1'b0, r_b});
  assign w_rs_sub = w_rs - {1'b0, r_b};
  assign w_quot   = {r_mplier[W-2:0], w_ge};
`endif

  always_comb begin
    w_res = '0; w_res_neg = 1'b0; w_ovf = 1'b0; w_done = 1'b1;
    case (r_op)
      2'd0: begin w_res = w_sum[W-1:0]; w_ovf = (w_sum > MAXP_W1); end
      2'd1: begin w_res = w_diff; w_res_neg = w_a_lt_b; w_ovf = w_a_lt_b && (w_diff > MAXN_W); end
      2'd2: begin w_res = w_prod[W-1:0]; w_ovf = (w_prod > MAXP_2W); w_done = w_last; end
`ifdef CALC_DIV_EN
      2'd3: begin w_res = w_quot; w_ovf = (r_b == '0); w_done = w_last || (r_b == '0); end
`endif
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    if (reset) w_next = ENTRY_A;
    else case (r_state)
      ENTRY_A: if (w_accept && w_is_op) w_next = ENTRY_B;
      ENTRY_B: if (w_accept && w_clear) w_next = ENTRY_A;
               else if (w_accept && w_eq) w_next = CALC;
      CALC:    if (w_done) w_next = w_ovf ? ERROR : CONV;
      CONV:    if (w_last) w_next = SHOW;
      SHOW:    if (w_accept && (w_is_digit || w_clear)) w_next = ENTRY_A;
               else if (w_accept && w_is_op && !r_neg) w_next = ENTRY_B;
      ERROR:   if (w_accept && (w_is_digit || w_clear)) w_next = ENTRY_A;
      default: w_next = ENTRY_A;
    endcase
  end

  genvar gi;
  logic [6:0] w_seg [NDIGITS];
  generate
    for (gi = 0; gi < NDIGITS; gi++) begin : g_digit
      assign w_bcd_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ? r_bcd[4*gi +: 4] + 4'd3
                                                             : r_bcd[4*gi +: 4];
      assign w_seg[gi] = seg7(r_bcd[4*gi +: 4]);
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset || (w_accept && w_clear)) begin
      r_state <= ENTRY_A; r_a <= '0; r_b <= '0; r_op <= 2'd0; r_bcd <= '0;
      r_ndig <= '0; r_neg <= 1'b0; r_fresh <= 1'b0; r_cnt <= '0;
      r_acc <= '0; r_mcand <= '0; r_mplier <= '0; r_bin <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        CALC: begin
          r_cnt    <= r_cnt + 1'b1;
          r_acc    <= w_prod;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
`ifdef CALC_DIV_EN
          if (r_op == 2'd3) begin
            r_acc    <= {{W{1'b0}}, w_ge ? w_rs_sub[W-1:0] : w_rs[W-1:0]};
            r_mplier <= w_quot;
          end
`endif
          if (w_done) begin
            r_a <= w_res; r_bin <= w_res; r_neg <= w_res_neg; r_bcd <= '0; r_cnt <= '0;
          end
        end
        CONV: begin
          r_cnt <= r_cnt + 1'b1;
          {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
        end
        default: if (w_accept) begin
          if (w_is_digit && w_dig_ok) begin
            if (r_state == ENTRY_B) r_b <= w_dig_val;
            else                    r_a <= w_dig_val;
            r_bcd <= {w_base_bcd[BW-5:0], cmd}; r_ndig <= w_dig_cnt;
            r_fresh <= 1'b0; r_neg <= 1'b0;
          end else if (w_is_op && r_state != ERROR && !(r_state == SHOW && r_neg)) begin
            r_op <= w_op_code;
            if (r_state != ENTRY_B) begin r_b <= '0; r_ndig <= '0; r_fresh <= 1'b1; end
          end else if (w_eq && r_state == ENTRY_B) begin
            r_cnt <= '0; r_acc <= '0; r_mcand <= {{W{1'b0}}, r_a}; r_mplier <= r_b;
`ifdef CALC_DIV_EN
            if (r_op == 2'd3) r_mplier <= r_a;
`endif
          end
        end
      endcase
    end
  end

  logic [3:0] w_msd;
  always_comb begin
    w_msd = '0;
    for (int i = 0; i < NDIGITS; i++)
      if (r_bcd[4*i +: 4] != 4'd0) w_msd = 4'(i);
    for (int i = 0; i < NDIGITS; i++) begin
      displays[i] = (4'(i) <= w_msd) ? w_seg[i] : 7'b0;
      if (r_state == SHOW && r_neg && 4'(i) == w_msd + 4'd1) displays[i] = 7'b1000000;
      if (r_state == ERROR)
        displays[i] = (i == 2) ? 7'b1111001 : ((i < 2) ? 7'b1010000 : 7'b0);
    end
  end

  always_comb begin
    status = 2'b00;
    if (busy)                      status = 2'b01;
    else if (r_state == ERROR)     status = 2'b10;
    else if (r_state == SHOW && r_neg) status = 2'b11;
  end

  assign EA = r_state;
  assign PE = w_next;
endmodule

// File: tb/tb_calc_core_param.sv
// tb_calc_core_param: directed vectors for calc_core_param at NDIGITS=8 (W=27).
// Honours CALC_DIV_EN to pick the divide or reserved-command vectors.
module tb_calc_core_param;
  localparam int N = 8;
  localparam logic [3:0] ADD = 4'd10, SUB = 4'd11, MUL = 4'd12, CLR = 4'd13, EQ = 4'd14, RSV = 4'd15;
  localparam logic [63:0] ERR_DISP = (64'h79 << 14) | (64'h50 << 7) | 64'h50;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [3:0]       cmd = 4'd0;
  logic             cmd_valid = 1'b0;
  logic [N-1:0][6:0] displays;
  logic [1:0]       status;
  logic             busy;
  logic [2:0]       EA, PE;
  int checks = 0;
  int errors = 0;
  int n;

  always #5 clock = ~clock;

  calc_core_param #(.NDIGITS(N)) dut (
    .clock(clock), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
    .displays(displays), .status(status), .busy(busy), .EA(EA), .PE(PE)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else
      $display("ok   %s: %0h", tag, got);
  endtask

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: seg = 7'h3F; 1: seg = 7'h06; 2: seg = 7'h5B; 3: seg = 7'h4F; 4: seg = 7'h66;
      5: seg = 7'h6D; 6: seg = 7'h7D; 7: seg = 7'h07; 8: seg = 7'h7F; 9: seg = 7'h6F;
      default: seg = 7'h00;
    endcase
  endfunction

  // Expected segment image of a decimal value, optional minus sign left of the top digit.
  function automatic logic [63:0] num(input longint v, input bit neg);
    logic [63:0] r = '0;
    int i = 0;
    do begin
      r = r | (64'(seg(int'(v % 10))) << (7 * i));
      v = v / 10;
      i++;
    end while (v > 0);
    if (neg) r = r | (64'h40 << (7 * i));
    return r;
  endfunction

  // Called at a falling edge; cmd is sampled on the following rising edge.
  task automatic send(input logic [3:0] c);
    cmd = c;
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic send_digits(input string s);
    for (int i = 0; i < s.len(); i++) send(4'(s[i] - 8'd48));
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 300) begin
      @(negedge clock);
      cycles++;
    end
    if (cycles >= 300) check("busy_timeout", 64'(cycles), 64'd0);
  endtask

  task automatic run_eq(output int cycles);
    send(EQ);
    wait_idle(cycles);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_disp",   64'(displays), num(0, 0));
    check("rst_status", 64'(status), 64'd0);
    check("rst_busy",   64'(busy), 64'd0);
    check("rst_ea",     64'(EA), 64'd0);

    send_digits("005");
    check("lead_zero_disp", 64'(displays), num(5, 0));
    send(CLR);

    send_digits("12");
    check("entry_12", 64'(displays), num(12, 0));
    cmd = MUL; cmd_valid = 1'b1;
    #1 check("pe_on_op", 64'(PE), 64'd1);
    @(negedge clock); cmd_valid = 1'b0;
    check("op_keeps_a", 64'(displays), num(12, 0));
    check("op_ea", 64'(EA), 64'd1);
    send(3);
    check("entry_b_3", 64'(displays), num(3, 0));
    run_eq(n);
    check("mul_busy_cycles", 64'(n), 64'd54);
    check("mul_ea", 64'(EA), 64'd4);
    check("mul_disp", 64'(displays), num(36, 0));
    check("mul_status", 64'(status), 64'd0);

    send(CLR); send(5); send(SUB); send(9);
    run_eq(n);
    check("sub_busy_cycles", 64'(n), 64'd28);
    check("sub_neg_disp", 64'(displays), num(4, 1));
    check("sub_neg_status", 64'(status), 64'd3);
    send(ADD);
    check("neg_op_ignored", 64'(EA), 64'd4);

    send(CLR);
    send_digits("99999999");
    check("max_entry", 64'(displays), num(99999999, 0));
    send(ADD); send(1);
    run_eq(n);
    check("ovf_ea", 64'(EA), 64'd5);
    check("ovf_disp", 64'(displays), ERR_DISP);
    check("ovf_status", 64'(status), 64'd2);
    send(EQ);
    check("err_eq_ignored", 64'(EA), 64'd5);
    send(CLR);
    check("clr_disp", 64'(displays), num(0, 0));
    check("clr_status", 64'(status), 64'd0);
    check("clr_ea", 64'(EA), 64'd0);

    send_digits("123456789");
    check("ninth_digit_ignored", 64'(displays), num(12345678, 0));

    send(CLR); send(7); send(ADD); send(8);
    send(EQ);
    send(5);
    wait_idle(n);
    check("drop_while_busy", 64'(displays), num(15, 0));
    check("drop_ea", 64'(EA), 64'd4);
    send(ADD);
    check("chain_keeps_result", 64'(displays), num(15, 0));
    check("chain_ea", 64'(EA), 64'd1);
    send(5);
    run_eq(n);
    check("chain_disp", 64'(displays), num(20, 0));

`ifdef CALC_DIV_EN
    send(CLR); send(9); send(RSV); send(2);
    run_eq(n);
    check("div_disp", 64'(displays), num(4, 0));
    check("div_status", 64'(status), 64'd0);
    send(CLR); send(9); send(RSV); send(0);
    run_eq(n);
    check("div_zero_ea", 64'(EA), 64'd5);
    check("div_zero_status", 64'(status), 64'd2);
`else
    send(CLR); send(9); send(RSV);
    check("rsv_ignored_a", 64'(EA), 64'd0);
    check("rsv_disp", 64'(displays), num(9, 0));
    send(ADD); send(RSV); send(2);
    run_eq(n);
    check("rsv_keeps_add", 64'(displays), num(11, 0));
`endif

    send(CLR); send(1); send(ADD); send(1);
    send(EQ);
    repeat (3) @(negedge clock);
    check("in_conv", 64'(EA), 64'd3);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rst_conv_busy", 64'(busy), 64'd0);
    check("rst_conv_disp", 64'(displays), num(0, 0));
    check("rst_conv_ea", 64'(EA), 64'd0);
    check("rst_conv_status", 64'(status), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/calc_core_param.md
Name: calc_core_param

Overview:
- Parametrised successor of the 4-bit-command calculator top: N-digit decimal entry, add/sub/multiply, signed result display, overflow error state, busy handshake.
- Sits between the keypad/command decoder and the 7-segment display bank; FSM state is exported for debug (EA/PE).
- Arithmetic is done in binary with multi-cycle multiply and multi-cycle binary-to-BCD conversion.

Parameters:
- NDIGITS, 8, number of decimal digits entered and displayed (2..9).
- W (localparam, derived), ceil(log2(10^NDIGITS)), binary operand width; 27 for NDIGITS=8.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd  in  4  0000-1001 digit 0-9; 1010 add; 1011 sub; 1100 mul; 1101 clear; 1110 equals; 1111 reserved
- cmd_valid  in  1  one-cycle strobe; cmd is sampled only when high
- displays  out  NDIGITS x 7  per-digit segments, index 0 = least significant; bit0=a..bit6=g, active-high
- status  out  2  00 ok, 01 busy, 10 error, 11 negative result
- busy  out  1  high in CALC/CONV; commands are dropped while high
- EA  out  3  current state
- PE  out  3  next state (combinational)

Behaviour:
- States: ENTRY_A=0, ENTRY_B=1, CALC=2, CONV=3, SHOW=4, ERROR=5.
- Reset (sampled on clock edge): A=B=0, op=add, state ENTRY_A.
  - Outputs: digit0 shows "0", other digits blank (0000000), status 00, busy 0, EA=0.
- Digit entry (ENTRY_A/ENTRY_B):
  - Operand = operand*10 + d, and d is shifted into a BCD entry register.
  - The display shows the entry register one cycle after cmd_valid, with leading zeros blanked.
  - A digit 0 on a zero operand does not increase the count.
  - The (NDIGITS+1)th digit is ignored.
- Op cmd:
  - In ENTRY_A: latch op, go to ENTRY_B, B=0. The display keeps A until B's first digit.
  - In ENTRY_B: replaces op; B is unchanged.
- Equals:
  - In ENTRY_B: go to CALC.
  - In ENTRY_A, SHOW or ERROR: ignored.
- CALC:
  - Add/sub take 1 cycle.
  - Mul is an iterative shift-add over W cycles.
  - Sub with A<B yields magnitude B-A with the negative flag set.
  - Then go to CONV, unless there is an overflow, in which case go to ERROR.
- Overflow rules:
  - Positive result > 10^NDIGITS-1 is an overflow.
  - Negative magnitude > 10^(NDIGITS-1)-1 is an overflow.
  - Multiply overflow is detected on the full 2W-bit product.
- CONV: double-dabble, exactly W cycles, then SHOW.
- Busy timing for equals accepted at cycle 0:
  - Add/sub: busy cycles 1..W+1, SHOW at cycle W+2.
  - Mul: busy cycles 1..2W, SHOW at cycle 2W+1.
- SHOW display and status:
  - Result digits with leading zeros blanked.
  - Negative: segment g only (1000000) in the digit immediately left of the most significant digit.
  - status 11 if negative, else 00.
- From SHOW:
  - Digit: starts a new A entry (result discarded).
  - Op with non-negative result: A=result, go to ENTRY_B (chaining).
  - Op with negative result: ignored.
- ERROR:
  - Digits 2..0 show "E","r","r" (1111001, 1010000, 1010000); others blank; status 10.
  - Leaves ERROR only via clear, digit (new entry) or reset.
- Clear: in any non-busy state, behaves as reset except that it does not affect anything outside this block.
- cmd_valid while busy: dropped, with no buffering and no status change.
- Reserved cmd 1111: ignored (see Optional Feature).
- Reset mid-CALC/CONV: abort; reset values on the next cycle.

Optional Feature:
- CALC_DIV_EN defined:
  - cmd 1111 = divide, integer quotient via restoring division over W cycles in CALC.
  - B=0 → ERROR.
  - Quotient is always non-negative.
- CALC_DIV_EN undefined: 1111 is ignored in every state; no divider logic is synthesised.

Test Plan:
- Reset; 1,2,mul,3,equals → busy for 54 cycles, then displays "36", status 00, EA=4.
- 5,sub,9,equals → displays "-4" (digit1=1000000, digit0=4), status 11.
- Eight 9s, add, 1, equals → ERROR, "Err", status 10; then clear → "0", status 00, EA=0.
- Digits 1..9 entered → display "12345678"; 9th digit ignored.
- 7,add,8,equals → "15"; add,5,equals → "20".
  - Strobe a digit during busy → dropped, result unchanged.
- Assert reset during CONV → next cycle busy 0, "0" displayed, EA=0.
- With CALC_DIV_EN defined:
  - 9,1111,2,equals → "4".
  - 9,1111,0,equals → ERROR.
